// File: rtl/alu_exec_ctrl_if.sv
// Issue and writeback channels of the XM23 execute-stage sequencer.
// slave = the controller, master = the decode/writeback side driving it.
interface alu_exec_ctrl_if #(
    parameter int W    = 16,
    parameter int OP_W = 41,
    parameter int RI_W = 3
);
    // Both channels: a transfer happens on a rising edge where valid & ready are both 1;
    // the sender holds valid and its payload stable until that edge; ready may depend on state only.
    logic            issue_valid;
    logic            issue_ready;
    logic [OP_W-1:0] issue_op;
    logic [W-1:0]    issue_a;
    logic [W-1:0]    issue_b;
    logic [RI_W-1:0] issue_dst;

    logic            wb_valid;
    logic            wb_ready;
    logic            wb_we;
    logic [RI_W-1:0] wb_dst;
    logic [W-1:0]    wb_data;

    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_dst, wb_ready,
        input  issue_ready, wb_valid, wb_we, wb_dst, wb_data
    );

    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_dst, wb_ready,
        output issue_ready, wb_valid, wb_we, wb_dst, wb_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// XM23 execute-stage sequencer: latches one op, drives the ALU, owns PSW {V,N,Z,C}, hands result to WB.
// Optional macro PSW_WR_EN adds a software PSW write port (psw_wr / psw_wr_data).
module alu_exec_ctrl #(
    parameter int W    = 16,
    parameter int OP_W = 41,
    parameter int RI_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    alu_exec_ctrl_if.slave  bus,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OP_W-1:0] alu_enable,
    output logic            alu_carry_in,
    input  logic [W-1:0]    alu_result,
    input  logic            alu_psw_en,
    output logic [3:0]      psw,
`ifdef PSW_WR_EN
    input  logic            psw_wr,
    input  logic [3:0]      psw_wr_data,
`endif
    output logic [1:0]      dbg_state
);
    localparam int OP_ADD  = 9;
    localparam int OP_ADDC = 10;
    localparam int OP_SUB  = 11;
    localparam int OP_SUBC = 12;
    localparam int OP_DADD = 13;
    localparam int OP_CMP  = 14;
    localparam int OP_BIT  = 18;
    localparam int OP_LMIN = 15;
    localparam int OP_LMAX = 20;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [OP_W-1:0] en_q, en_d;
    logic [RI_W-1:0] dst_q, dst_d;
    logic [3:0]      psw_q, psw_d;
    logic            wb_we_q, wb_we_d;
    logic [RI_W-1:0] wb_dst_q, wb_dst_d;
    logic [W-1:0]    wb_data_q, wb_data_d;

    logic            accept;
    logic            has_op, is_sub, cin, we_calc, v_calc;
    int              sel;
    logic [W-1:0]    b_eff;
    logic [W:0]      sum;
    logic [3:0]      flags;

    assign bus.issue_ready = !flush && (state_q == S_IDLE || (state_q == S_DONE && bus.wb_ready));
    assign accept          = bus.issue_valid && bus.issue_ready;
    assign bus.wb_valid    = (state_q == S_DONE);
    assign bus.wb_we       = wb_we_q;
    assign bus.wb_dst      = wb_dst_q;
    assign bus.wb_data     = wb_data_q;
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign alu_enable      = en_q;
    assign alu_carry_in    = psw_q[0];
    assign psw             = psw_q;
    assign dbg_state       = state_q;

    // Flags follow the lowest set op bit, mirroring the ALU's own priority.
    always_comb begin
        sel = -1;
        for (int i = OP_W - 1; i >= 0; i--) begin
            if (en_q[i]) sel = i;
        end
        has_op  = |en_q;
        is_sub  = (sel == OP_SUB) || (sel == OP_SUBC) || (sel == OP_CMP);
        cin     = (sel == OP_SUB || sel == OP_CMP) ? 1'b1 :
                  (sel == OP_ADDC || sel == OP_SUBC) ? psw_q[0] : 1'b0;
        b_eff   = is_sub ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {{W{1'b0}}, cin};
        v_calc  = (a_q[W-1] == b_eff[W-1]) && (sum[W-1] != a_q[W-1]);
        we_calc = has_op && (sel != OP_CMP) && (sel != OP_BIT);
        if (sel >= OP_ADD && sel <= OP_CMP && sel != OP_DADD)
            flags = {v_calc, alu_result[W-1], alu_result == '0, sum[W]};
        else if (sel >= OP_LMIN && sel <= OP_LMAX)
            flags = {1'b0, alu_result[W-1], alu_result == '0, psw_q[0]};
        else
            flags = {psw_q[3], alu_result[W-1], alu_result == '0, psw_q[0]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        en_d      = en_q;
        dst_d     = dst_q;
        psw_d     = psw_q;
        wb_we_d   = wb_we_q;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
        if (flush) begin
            state_d = S_IDLE;
            en_d    = '0;
            wb_we_d = 1'b0;
        end else begin
            case (state_q)
                S_EXEC: begin
                    state_d   = S_DONE;
                    en_d      = '0;
                    wb_data_d = alu_result;
                    wb_we_d   = we_calc;
                    wb_dst_d  = dst_q;
                    if (alu_psw_en && has_op) psw_d = flags;
                end
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_d = S_EXEC;
                        a_d     = bus.issue_a;
                        b_d     = bus.issue_b;
                        en_d    = bus.issue_op;
                        dst_d   = bus.issue_dst;
                    end else if (state_q == S_DONE && bus.wb_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef PSW_WR_EN
        // Software write beats ALU capture and is not blocked by flush.
        if (psw_wr) psw_d = psw_wr_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            en_q      <= '0;
            dst_q     <= '0;
            psw_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            en_q      <= en_d;
            dst_q     <= dst_d;
            psw_q     <= psw_d;
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural XM23 ALU stand-in plus an arithmetic reference model.
// Build with +define+PSW_WR_EN to also exercise the software PSW write.
module tb_alu_exec_ctrl;
  localparam int W = 16;
  localparam int OP_W = 41;
  localparam int RI_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [OP_W-1:0] alu_enable;
  logic alu_carry_in, alu_psw_en;
  logic [3:0] psw;
  logic [1:0] dbg_state;
`ifdef PSW_WR_EN
  logic psw_wr = 1'b0;
  logic [3:0] psw_wr_data = 4'h0;
`endif

  int total = 0;
  int fails = 0;
  logic [3:0] exp_psw = 4'h0;
  logic [W-1:0] last_data = '0;
  logic [W-1:0] exp_q[$];
  logic [7:0] exp_meta_q[$];
  int alu_k;

  alu_exec_ctrl_if #(.W(W), .OP_W(OP_W), .RI_W(RI_W)) bus ();

  alu_exec_ctrl #(.W(W), .OP_W(OP_W), .RI_W(RI_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_psw_en(alu_psw_en), .psw(psw),
`ifdef PSW_WR_EN
    .psw_wr(psw_wr), .psw_wr_data(psw_wr_data),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int lowest(input logic [OP_W-1:0] op);
    int k;
    k = -1;
    for (int i = OP_W - 1; i >= 0; i--) if (op[i]) k = i;
    return k;
  endfunction

  function automatic logic [W-1:0] alu_fn(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic [W-1:0] r;
    int c, d;
    r = '0;
    case (k)
      9: r = a + b;
      10: r = a + b + 16'(cin);
      11, 14: r = a - b;
      12: r = a + ~b + 16'(cin);
      13: begin
        c = int'(cin);
        for (int n = 0; n < 4; n++) begin
          d = int'(a[4*n+:4]) + int'(b[4*n+:4]) + c;
          if (d > 9) begin d = d - 10; c = 1; end else c = 0;
          r[4*n+:4] = 4'(d);
        end
      end
      15: r = a ^ b;
      16, 18: r = a & b;
      17, 20: r = a | b;
      19: r = a & ~b;
      21: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stand-in ALU: lowest enable bit wins, flags enabled for ADD..BIS only.
  always_comb begin
    alu_k = lowest(alu_enable);
    alu_result = alu_fn(alu_k, alu_a, alu_b, alu_carry_in);
    alu_psw_en = (alu_k >= 9) && (alu_k <= 20);
  end

  // Reference: flags from plain integer arithmetic on unsigned and signed views.
  function automatic void ref_exec(input logic [OP_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] pin, output logic [W-1:0] r, output logic we,
                                   output logic [3:0] pout);
    int k, ua, ub, sa, sb, c, full, sfull;
    k = lowest(op);
    c = int'(pin[0]);
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = alu_fn(k, a, b, pin[0]);
    we = (k >= 0) && (k != 14) && (k != 18);
    pout = pin;
    full = 0;
    sfull = 0;
    case (k)
      9: begin full = ua + ub; sfull = sa + sb; end
      10: begin full = ua + ub + c; sfull = sa + sb + c; end
      11, 14: begin full = ua + (65535 - ub) + 1; sfull = sa - sb; end
      12: begin full = ua + (65535 - ub) + c; sfull = sa - sb - 1 + c; end
      default: ;
    endcase
    if (k >= 9 && k <= 14 && k != 13)
      pout = {(sfull > 32767) || (sfull < -32768), r[15], r == 16'h0, full > 65535};
    else if (k == 13)
      pout = {pin[3], r[15], r == 16'h0, pin[0]};
    else if (k >= 15 && k <= 20)
      pout = {1'b0, r[15], r == 16'h0, pin[0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present an op (optionally after holding WB stalled), check the EXEC cycle
  task automatic send(input logic [OP_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [RI_W-1:0] dst, input int stall);
    logic [W-1:0] r;
    logic we;
    logic [3:0] pn;
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_a = a;
    bus.issue_b = b;
    bus.issue_dst = dst;
    if (stall > 0) begin
      bus.wb_ready = 1'b0;
      #1;
      for (int s = 0; s < stall; s++) begin
        chk("stall_issue_ready", 64'(bus.issue_ready), 64'd0);
        chk("stall_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("stall_wb_data", 64'(bus.wb_data), 64'(last_data));
        chk("stall_psw", 64'(psw), 64'(exp_psw));
        @(posedge clk); #1;
      end
      bus.wb_ready = 1'b1;
    end
    #1;
    chk("issue_ready", 64'(bus.issue_ready), 64'd1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    chk("exec_state", 64'(dbg_state), 64'd1);
    chk("alu_enable", 64'(alu_enable), 64'(op));
    chk("alu_a", 64'(alu_a), 64'(a));
    chk("alu_b", 64'(alu_b), 64'(b));
    chk("alu_carry_in", 64'(alu_carry_in), 64'(exp_psw[0]));
    ref_exec(op, a, b, exp_psw, r, we, pn);
    exp_psw = pn;
    exp_q.push_back(r);
    exp_meta_q.push_back({we, dst, pn});
  endtask

  // scoreboard: one edge after EXEC the result must be presented
  task automatic collect();
    logic [W-1:0] ed;
    logic [7:0] em;
    @(posedge clk); #1;
    ed = exp_q.pop_front();
    em = exp_meta_q.pop_front();
    chk("wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("wb_data", 64'(bus.wb_data), 64'(ed));
    chk("wb_we", 64'(bus.wb_we), 64'(em[7]));
    chk("wb_dst", 64'(bus.wb_dst), 64'(em[6:4]));
    chk("psw", 64'(psw), 64'(em[3:0]));
    last_data = ed;
  endtask

  function automatic logic [OP_W-1:0] onehot(input int k);
    logic [OP_W-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [OP_W-1:0] op;
    int k;
    bus.issue_valid = 1'b0;
    bus.issue_op = '0;
    bus.issue_a = '0;
    bus.issue_b = '0;
    bus.issue_dst = '0;
    bus.wb_ready = 1'b1;

    #12;
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_psw", 64'(psw), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_wb_we", 64'(bus.wb_we), 64'd0);
    chk("rst_wb_dst", 64'(bus.wb_dst), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'd0);
    chk("rst_alu_enable", 64'(alu_enable), 64'd0);

    // ADD overflow, CMP equal, then SUBC using the carry CMP left behind
    send(onehot(9), 16'h7FFF, 16'h0001, 3'd1, 0);
    collect();
    chk("add_psw_literal", 64'(psw), 64'hC);
    send(onehot(14), 16'h0005, 16'h0005, 3'd2, 0);
    collect();
    chk("cmp_psw_literal", 64'(psw), 64'h3);
    send(onehot(12), 16'h0003, 16'h0001, 3'd3, 0);
    collect();
    chk("subc_data_literal", 64'(bus.wb_data), 64'h2);

    // WB held off 5 cycles with the next op waiting
    send(onehot(9), 16'h1234, 16'h1111, 3'd4, 0);
    collect();
    send(onehot(11), 16'h0100, 16'h0001, 3'd5, 5);
    collect();

    // MOV and no-op leave PSW alone after ADD sets C
    send(onehot(9), 16'hFFFF, 16'h0001, 3'd6, 0);
    collect();
    chk("add_carry_literal", 64'(psw), 64'h3);
    send(onehot(21), 16'h0000, 16'hABCD, 3'd7, 0);
    collect();
    chk("mov_psw_literal", 64'(psw), 64'h3);
    send('0, 16'h1111, 16'h2222, 3'd0, 0);
    collect();
    chk("noop_we_literal", 64'(bus.wb_we), 64'd0);

    // flush wins over wb_ready and over a waiting op in DONE
    bus.issue_valid = 1'b1;
    bus.issue_op = onehot(9);
    flush = 1'b1;
    #1;
    chk("flush_done_ready", 64'(bus.issue_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.issue_valid = 1'b0;
    chk("flush_done_state", 64'(dbg_state), 64'd0);
    chk("flush_done_wb_valid", 64'(bus.wb_valid), 64'd0);

    // flush during EXEC of SUB 0-1 after PSW cleared by ADD 1+1
    send(onehot(9), 16'h0001, 16'h0001, 3'd1, 0);
    collect();
    chk("add_clear_psw", 64'(psw), 64'h0);
    bus.issue_valid = 1'b1;
    bus.issue_op = onehot(11);
    bus.issue_a = 16'h0000;
    bus.issue_b = 16'h0001;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    chk("flush_exec_entered", 64'(dbg_state), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_issue_ready", 64'(bus.issue_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_exec_state", 64'(dbg_state), 64'd0);
    chk("flush_exec_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("flush_exec_psw", 64'(psw), 64'h0);
    chk("flush_exec_enable", 64'(alu_enable), 64'd0);
    @(posedge clk); #1;
    chk("flush_exec_no_wb", 64'(bus.wb_valid), 64'd0);

    // randomized ops, some with extra higher-index bits and WB stalls
    send(onehot(16), 16'h00FF, 16'h0F0F, 3'd2, 0);
    collect();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 13);
      op = (k == 13) ? '0 : onehot(k + 9);
      if (k != 13 && $urandom_range(0, 3) == 0) op = op | onehot($urandom_range(k + 10, OP_W - 1));
      send(op, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 2));
      collect();
    end

`ifdef PSW_WR_EN
    send(onehot(9), 16'h0001, 16'h0001, 3'd3, 0);
    psw_wr = 1'b1;
    psw_wr_data = 4'hF;
    exp_psw = 4'hF;
    exp_meta_q[exp_meta_q.size() - 1][3:0] = 4'hF;
    collect();
    psw_wr = 1'b0;
`endif

    // async reset while holding a result in DONE
    send(onehot(9), 16'h7FFF, 16'h7FFF, 3'd4, 0);
    collect();
    rst_n = 1'b0;
    #2;
    chk("midrst_psw", 64'(psw), 64'h0);
    chk("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("midrst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("midrst_wb_we", 64'(bus.wb_we), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    exp_psw = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(onehot(9), 16'h0002, 16'h0003, 3'd5, 0);
    collect();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
